// File: rtl/combine_stream_arb_if.sv
// Stream bundle around combine_stream_arb: NUM_INPUTS framed inputs
// joined into one output. slave = combiner side, master = environment.
//   i_tdata/i_tlast/i_tvalid/i_tready : per-input AXI-stream lanes
//   o_tdata/o_tlast/o_tvalid/o_tready : merged output stream
//   o_tdest                           : source index of output beat
interface combine_stream_arb_if #(
    parameter int WIDTH      = 160,
    parameter int NUM_INPUTS = 2
);
    logic [NUM_INPUTS*WIDTH-1:0] i_tdata;
    logic [NUM_INPUTS-1:0]       i_tlast;
    logic [NUM_INPUTS-1:0]       i_tvalid;
    logic [NUM_INPUTS-1:0]       i_tready;
    logic [WIDTH-1:0]            o_tdata;
    logic                        o_tlast;
    logic                        o_tvalid;
    logic                        o_tready;
    logic [1:0]                  o_tdest;

    modport slave (
        input  i_tdata,
        input  i_tlast,
        input  i_tvalid,
        output i_tready,
        output o_tdata,
        output o_tlast,
        output o_tvalid,
        output o_tdest,
        input  o_tready
    );

    modport master (
        output i_tdata,
        output i_tlast,
        output i_tvalid,
        input  i_tready,
        input  o_tdata,
        input  o_tlast,
        input  o_tvalid,
        input  o_tdest,
        output o_tready
    );
endinterface

// File: rtl/combine_stream_arb.sv
// Packet-level round-robin N:1 combiner for framed {tuser,tdata} streams.
// Ports: clk; reset_n (sync, active-low); clear (sync, active-high);
//   s (combine_stream_arb_if.slave): per-input lanes in, merged out,
//   o_tdest source index; pkt_count: output packets completed (wraps).
// Macro COMBINE_STREAM_OUTREG_EN: registered output via 2-entry skid
//   buffer; undefined: combinational pass-through from granted input.
module combine_stream_arb #(
    parameter int         WIDTH       = 160,
    parameter int         NUM_INPUTS  = 2,
    parameter logic [3:0] ACTIVE_MASK = 4'b0011
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    combine_stream_arb_if.slave s,
    output logic [31:0]         pkt_count
);
    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [1:0] LP_LAST = 2'(NUM_INPUTS - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_grant;
    logic [1:0]            w_grant_nxt;
    logic [1:0]            r_last_grant;
    logic [1:0]            w_last_grant_nxt;
    logic [31:0]           r_pkt_count;

    logic                  w_rst;
    logic                  w_active;
    logic [3:0]            w_req;
    logic                  w_found;
    logic [1:0]            w_pick;
    logic [1:0]            w_idx;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic [WIDTH-1:0]      w_sel_data;
    logic                  w_accept;
    logic                  w_in_hs;
    logic                  w_in_eop;
    logic                  w_out_eop;
    logic [NUM_INPUTS-1:0] w_ready;

    assign w_rst    = !reset_n || clear;
    assign w_active = (r_state == ACTIVE);
    assign w_req    = 4'(s.i_tvalid) & ACTIVE_MASK;

    // Round-robin search starting one past the last granted input.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 2'd0;
        w_idx   = r_last_grant;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_idx = (w_idx == LP_LAST) ? 2'd0 : w_idx + 2'd1;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (r_grant == 2'(k)) begin
                w_sel_valid = s.i_tvalid[k];
                w_sel_last  = s.i_tlast[k];
                w_sel_data  = s.i_tdata[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_in_hs  = w_active && w_sel_valid && w_accept;
    assign w_in_eop = w_in_hs && w_sel_last;

    always_comb begin
        w_ready = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            w_ready[k] = w_active && (r_grant == 2'(k)) && w_accept;
        end
    end

    assign s.i_tready = w_ready;

`ifdef COMBINE_STREAM_OUTREG_EN
    logic [WIDTH-1:0] r_dat [2];
    logic [1:0]       r_lst;
    logic [1:0]       r_dst [2];
    logic             r_wp;
    logic             r_rp;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    // Ready comes from buffer occupancy only, so no path from o_tready.
    assign w_accept = (r_cnt != 2'd2);
    assign w_push   = w_in_hs;
    assign w_pop    = (r_cnt != 2'd0) && s.o_tready;

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_dat[0] <= '0;
            r_dat[1] <= '0;
            r_lst    <= '0;
            r_dst[0] <= '0;
            r_dst[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_dat[r_wp] <= w_sel_data;
                r_lst[r_wp] <= w_sel_last;
                r_dst[r_wp] <= r_grant;
                r_wp        <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    assign s.o_tvalid = (r_cnt != 2'd0);
    assign s.o_tdata  = r_dat[r_rp];
    assign s.o_tlast  = r_lst[r_rp];
    assign s.o_tdest  = r_dst[r_rp];
    assign w_out_eop  = w_pop && r_lst[r_rp];
`else
    assign w_accept   = s.o_tready;
    assign s.o_tvalid = w_active && w_sel_valid;
    assign s.o_tdata  = w_active ? w_sel_data : '0;
    assign s.o_tlast  = w_active && w_sel_last;
    assign s.o_tdest  = r_grant;
    assign w_out_eop  = w_in_eop;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = ACTIVE;
                    w_grant_nxt = w_pick;
                end
            end
            ACTIVE: begin
                if (w_in_eop) begin
                    w_state_nxt      = IDLE;
                    w_last_grant_nxt = r_grant;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            r_state      <= IDLE;
            r_grant      <= 2'd0;
            r_last_grant <= LP_LAST;
            r_pkt_count  <= 32'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            if (w_out_eop) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign pkt_count = r_pkt_count;
endmodule
